axi_lite_reg_bank: RTL and testbench
====================================

# axi_lite_reg_bank

Parametrised AXI4-Lite slave register bank, the successor to the fixed four-register test slave. It provides NUM_REGS registers of DATA_WIDTH bits with byte-strobe writes, per-register read-only status inputs, SLVERR on illegal accesses and per-register write pulses. It sits behind the AXI VIP master, or an interconnect, in block-design wrappers and exposes the register contents to fabric logic.

## Interface
- DATA_WIDTH, 32: AXI data width, 32 or 64; ADDR_LSB = log2(DATA_WIDTH/8).
- ADDR_WIDTH, 6: AXI address width; requires NUM_REGS ≤ 2^(ADDR_WIDTH−ADDR_LSB).
- NUM_REGS, 8: number of registers, 1..64.
- RO_MASK, 0: NUM_REGS bits; bit i set makes register i read-only, sourced from status_in.
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR  in  ADDR_WIDTH; S_AXI_AWPROT  in  3 (ignored); S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  DATA_WIDTH; S_AXI_WSTRB  in  DATA_WIDTH/8; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  ADDR_WIDTH; S_AXI_ARPROT  in  3 (ignored); S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  DATA_WIDTH; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after register i is updated.
- status_in  in  NUM_REGS*DATA_WIDTH  read values for RO registers; slices of RW registers are unused.

## Operation
- Word index = ADDR[ADDR_WIDTH−1:ADDR_LSB]. Low ADDR_LSB bits are ignored, so unaligned addresses alias to their word.
- Write channel FSM, states W_IDLE and W_RESP.
  - W_IDLE: AWREADY = !aw_held and WREADY = !w_held. AW and W are captured independently, in either order or in the same cycle.
  - Commit happens on the edge where both AW and W are present (held, or handshaking that cycle). The FSM then moves to W_RESP.
  - Commit on a RW register in range: for each byte b with WSTRB[b]=1, that byte is updated; other bytes are kept. reg_wr_pulse[i] is set for one cycle, even when WSTRB=0. BRESP=OKAY.
  - Index ≥ NUM_REGS or a RO register: no state change, no pulse, BRESP=SLVERR (2'b10).
  - W_RESP: BVALID=1, AWREADY=WREADY=0. Return to W_IDLE on the edge where BVALID&&BREADY, clearing both held flags.
- Read channel FSM, states R_IDLE and R_RESP.
  - R_IDLE: ARREADY=1. On AR handshake, RDATA/RRESP are registered and the FSM moves to R_RESP.
  - RDATA: status_in slice for a RO register, register value for a RW register, 0 with SLVERR if out of range.
  - R_RESP: RVALID=1, ARREADY=0. RDATA/RRESP are held stable until RVALID&&RREADY, then the FSM returns to R_IDLE.
- The read and write channels are fully independent. A read accepted on the same edge as a write commit to the same register returns the pre-write value.

## Timing
- Reset (ARESETN low, asynchronous): all registers 0, reg_out=0, reg_wr_pulse=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, AWREADY=WREADY=ARREADY=0, held flags cleared, FSMs in IDLE. The READY outputs go to 1 on the first edge after reset release.
- Write latency: commit edge → BVALID high the next cycle; reg_out updated and reg_wr_pulse high in that same cycle.
- Read latency: AR handshake edge → RVALID high the next cycle. Best-case throughput is one read every 2 cycles and one write every 2 cycles.
- Back-to-back: after the B or R handshake, the matching READY is high in the following cycle. No combinational path from any VALID to any READY.
- Reset asserted mid-transaction aborts it: a held AW or W is discarded, pending BVALID/RVALID drop immediately, and no partial register update occurs.
- status_in is sampled only at the AR handshake edge; it is not required to be stable otherwise.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read them back → RDATA matches, all RESP=OKAY, reg_wr_pulse[0..3] each pulse once.
- Write 0xFFFFFFFF to 0x10, then write 0x000000AB with WSTRB=4'b0001 → readback 0xFFFFFFAB.
- W presented 3 cycles before AW → WREADY handshake first, AWREADY accepted later, then exactly one commit; BVALID rises the cycle after the AW handshake.
- Hold BREADY low 5 cycles → BVALID and BRESP stay stable, AWREADY=WREADY=0 throughout; a new AW is accepted the cycle after the BREADY handshake.
- Write to 0x20 (index 8 ≥ NUM_REGS) → BRESP=SLVERR, no reg_out change. Read 0x20 → RDATA=0, RRESP=SLVERR.
- RO_MASK=8'h80, status_in slice 7 = 0xCAFE0001. Write 0x1C → SLVERR with no change. Read 0x1C → 0xCAFE0001. Pull ARESETN low while RVALID=1 → RVALID drops immediately and reg_out=0.

Source files
------------

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS byte-strobed registers, optional
// read-only status slots, SLVERR on illegal accesses and per-register write pulses.
`timescale 1ns/1ps
module axi_lite_reg_bank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 6,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
);

  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam int         ADDR_LSB    = $clog2(STRB_W);
  localparam int         IDX_W       = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [IDX_W-1:0]      awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;

  logic                  aw_hs, w_hs, b_hs, commit;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  // A channel already held wins over the live bus, which is not ready anyway.
  assign aw_hs   = S_AXI_AWVALID && awready_q;
  assign w_hs    = S_AXI_WVALID && wready_q;
  assign b_hs    = bvalid_q && S_AXI_BREADY;
  assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_idx  = aw_held_q ? awidx_q : S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (commit) w_state_d = W_RESP;
      W_RESP:  if (b_hs)   w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awidx_d   = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
          bresp_d    = RESP_OKAY;
          pulse_d[i] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end
    end
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      // NOTE: the register array is architecturally visible on reg_out, so it is reset like any control flop.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      regs_q    <= regs_d;
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs, r_hs;
  logic [IDX_W-1:0]      rd_idx;

  assign ar_hs  = S_AXI_ARVALID && arready_q;
  assign r_hs   = rvalid_q && S_AXI_RREADY;
  assign rd_idx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (r_hs)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // regs_q (not regs_d) is read, so a same-edge write commit is not visible yet.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_idx == IDX_W'(i)) begin
          rresp_d = RESP_OKAY;
          rdata_d = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        end
      end
    end
    if (r_hs) rvalid_d = 1'b0;
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------- outputs ----------------
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0], status_in};

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank: directed cases plus randomized
// traffic against an array-based model of the register bank.
`timescale 1ns/1ps
module tb_axi_lite_reg_bank;
  localparam int             DW = 32;
  localparam int             AW = 6;
  localparam int             NR = 8;
  localparam logic [NR-1:0]  RO = 8'h80;

  logic             ACLK = 1'b0;
  logic             ARESETN = 1'b0;
  logic [AW-1:0]    S_AXI_AWADDR = '0;
  logic [2:0]       S_AXI_AWPROT = '0;
  logic             S_AXI_AWVALID = 1'b0;
  logic             S_AXI_AWREADY;
  logic [DW-1:0]    S_AXI_WDATA = '0;
  logic [DW/8-1:0]  S_AXI_WSTRB = '0;
  logic             S_AXI_WVALID = 1'b0;
  logic             S_AXI_WREADY;
  logic [1:0]       S_AXI_BRESP;
  logic             S_AXI_BVALID;
  logic             S_AXI_BREADY = 1'b0;
  logic [AW-1:0]    S_AXI_ARADDR = '0;
  logic [2:0]       S_AXI_ARPROT = '0;
  logic             S_AXI_ARVALID = 1'b0;
  logic             S_AXI_ARREADY;
  logic [DW-1:0]    S_AXI_RDATA;
  logic [1:0]       S_AXI_RRESP;
  logic             S_AXI_RVALID;
  logic             S_AXI_RREADY = 1'b0;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;
  logic [NR*DW-1:0] status_in = '0;

  axi_lite_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: one word per register; RO slots never change.
  logic [DW-1:0] model_regs [NR];

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
  endfunction

  function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                             input logic [3:0] s);
    int idx;
    idx = int'(a) / 4;
    if (idx >= NR || RO[idx]) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) model_regs[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                     output logic [1:0] r);
    int idx;
    idx = int'(a) / 4;
    if (idx >= NR) begin
      d = '0;
      r = 2'b10;
    end else begin
      d = RO[idx] ? status_in[idx*DW +: DW] : model_regs[idx];
      r = 2'b00;
    end
  endfunction

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model_regs[i];
    return f;
  endfunction

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0, idx;
    logic [1:0]    exp_resp;
    logic [NR-1:0] exp_pulse;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (w_done)  check("wready_held", S_AXI_WREADY, 0);
      if (aw_done) check("awready_held", S_AXI_AWREADY, 0);
      if (aw_done || w_done) check("no_early_bvalid", S_AXI_BVALID, 0);
      S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
      S_AXI_WVALID  = !w_done && cyc >= w_dly;
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      aw_done |= aw_fire;
      w_done  |= w_fire;
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("aw_w_accepted", aw_done && w_done, 1);
    if (!(aw_done && w_done)) return;
    idx       = int'(addr) / 4;
    exp_resp  = model_write(addr, data, strb);
    exp_pulse = '0;
    if (exp_resp == 2'b00) exp_pulse[idx] = 1'b1;
    check("bvalid_latency", S_AXI_BVALID, 1);
    check("wr_pulse", reg_wr_pulse, exp_pulse);
    check("reg_out", reg_out, model_flat());
    for (int k = 0; k < b_dly; k++) begin
      @(posedge ACLK); #1;
      check("bvalid_hold", S_AXI_BVALID, 1);
      check("bresp_hold", S_AXI_BRESP, exp_resp);
      check("ready_in_resp", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
      check("pulse_once", reg_wr_pulse, 0);
    end
    check("bresp", S_AXI_BRESP, exp_resp);
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    check("bvalid_drop", S_AXI_BVALID, 0);
    check("ready_after_b", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                          input logic [DW-1:0] exp_d, input logic [1:0] exp_r);
    bit done = 0, fire;
    int cyc = 0;
    S_AXI_ARADDR = addr;
    while (!done && cyc < 40) begin
      S_AXI_ARVALID = cyc >= ar_dly;
      fire = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      done |= fire;
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    check("ar_accepted", done, 1);
    if (!done) return;
    check("rvalid_latency", S_AXI_RVALID, 1);
    for (int k = 0; k < r_dly; k++) begin
      for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = $urandom;
      @(posedge ACLK); #1;
      check("rvalid_hold", S_AXI_RVALID, 1);
      check("arready_in_resp", S_AXI_ARREADY, 0);
    end
    check("rdata", S_AXI_RDATA, exp_d);
    check("rresp", S_AXI_RRESP, exp_r);
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    check("rvalid_drop", S_AXI_RVALID, 0);
    check("arready_after_r", S_AXI_ARREADY, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected completion before time limit");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    r;
    model_reset();

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
    check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 0);
    check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_reg_out", reg_out, 0);
    check("rst_pulse", reg_wr_pulse, 0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("ready_after_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Basic write/readback of four words
    for (int i = 0; i < 4; i++) axi_write(AW'(4 * i), DW'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(AW'(4 * i), 0, 0, DW'(i + 1), 2'b00);

    // Byte strobes
    axi_write(6'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(6'h10, 32'h0000_00AB, 4'b0001, 0, 0, 1);
    axi_read(6'h10, 0, 0, 32'hFFFF_FFAB, 2'b00);

    // W three cycles ahead of AW, then BREADY held low and back-to-back write
    axi_write(6'h14, 32'h1234_5678, 4'hF, 3, 0, 0);
    axi_write(6'h18, 32'h55AA_55AA, 4'hF, 0, 0, 5);
    axi_write(6'h08, 32'h0000_0033, 4'hF, 0, 0, 0);
    axi_read(6'h18, 0, 1, 32'h55AA_55AA, 2'b00);

    // Out of range and read-only
    axi_write(6'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_read(6'h20, 0, 0, 32'h0, 2'b10);
    status_in[7*DW +: DW] = 32'hCAFE_0001;
    axi_write(6'h1C, 32'h1111_2222, 4'hF, 0, 0, 0);
    axi_read(6'h1C, 0, 2, 32'hCAFE_0001, 2'b00);

    // Unaligned alias, then same-edge read and write to one register
    axi_write(6'h05, 32'h7777_0000, 4'b1100, 0, 0, 0);
    axi_read(6'h07, 0, 0, 32'h7777_0002, 2'b00);
    model_read(6'h08, d, r);
    fork
      axi_write(6'h08, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
      axi_read(6'h08, 0, 0, d, r);
    join
    axi_read(6'h08, 0, 0, 32'h0BAD_F00D, 2'b00);

    // Reset while a read response is pending and an AW is held
    S_AXI_ARADDR  = 6'h00;
    S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR  = 6'h04;
    S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWVALID = 1'b0;
    check("rvalid_before_rst", S_AXI_RVALID, 1);
    check("aw_held_before_rst", S_AXI_AWREADY, 0);
    ARESETN = 1'b0;
    #1;
    check("rvalid_async_drop", S_AXI_RVALID, 0);
    check("rdata_async_clear", S_AXI_RDATA, 0);
    check("reg_out_async_clear", reg_out, 0);
    check("ready_in_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
    model_reset();
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("aw_discarded", S_AXI_AWREADY, 1);
    S_AXI_WDATA  = 32'h0000_BEEF;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    repeat (2) begin
      @(posedge ACLK); #1;
    end
    check("no_commit_without_aw", {S_AXI_BVALID, reg_wr_pulse}, 0);
    check("reg_out_after_rst", reg_out, 0);
    S_AXI_AWADDR  = 6'h04;
    S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    void'(model_write(6'h04, 32'h0000_BEEF, 4'hF));
    check("late_aw_bvalid", S_AXI_BVALID, 1);
    check("late_aw_reg_out", reg_out, model_flat());
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      end else begin
        for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = $urandom;
        model_read(a, d, r);
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, r);
      end
    end
    check("final_reg_out", reg_out, model_flat());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
